spi_frame_master: RTL

SPI master that issues fixed 32-bit, MSB-first frames to the sensor-side `spi_slave` and captures the slave's 32-bit reply. It owns `sck`, generating it from the system clock by a programmable divider. It gives the signal-processing bench and MCU-less builds an on-FPGA initiator for the same wire protocol the slave decodes. A start/busy/done handshake lets a sequencer request one frame at a time.

---
 rtl/spi_frame_master.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/spi_frame_master.sv
// SPI master issuing fixed 32-bit MSB-first frames with a programmable sck divider.
// Captures the slave's 32-bit reply and reports it with a one-cycle done pulse.
//
// state | meaning
// IDLE  | sck low, waiting for start
// SHIFT | divider running, 32 sck pulses exchanged
// TAIL  | sck held low for one half-period before done
module spi_frame_master #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] tx_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] rx_data,
    output logic        sck,
    output logic        sdo,
    input  logic        sdi
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        TAIL  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [DIV_W-1:0] div_cnt;
    logic [5:0]       bit_cnt;
    logic [31:0]      tx_sr;
    logic [31:0]      rx_sr;
    logic             tick;
    logic             accept;
    logic             fall;
    logic             last_fall;
    logic             tail_end;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        fall      = 1'b0;
        last_fall = 1'b0;
        tail_end  = 1'b0;
        tick      = (state != IDLE) && (div_cnt == DIV_LAST);
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (tick && sck) begin
                    fall = 1'b1;
                    // bit_cnt stops at 32; the 32nd fall ends the shift phase
                    if (bit_cnt == 6'd31) begin
                        last_fall = 1'b1;
                        state_nxt = TAIL;
                    end
                end
            end
            TAIL: begin
                if (tick) begin
                    tail_end  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            rx_data <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sck     <= 1'b0;
            sdo     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        tx_sr   <= tx_data;
                        sdo     <= tx_data[31];
                        rx_sr   <= '0;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        sck     <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                SHIFT: begin
                    div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
                    if (tick) begin
                        sck <= ~sck;
                    end
                    if (fall) begin
                        rx_sr   <= {rx_sr[30:0], sdi};
                        tx_sr   <= {tx_sr[30:0], 1'b0};
                        bit_cnt <= bit_cnt + 6'd1;
                        sdo     <= last_fall ? 1'b0 : tx_sr[30];
                    end
                end
                TAIL: begin
                    div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
                    if (tail_end) begin
                        rx_data <= rx_sr;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    busy <= 1'b0;
                    sck  <= 1'b0;
                    sdo  <= 1'b0;
                end
            endcase
        end
    end

endmodule
